sdf_stage_ctrl: RTL

- Sequencing controller for one radix-2 single-path delay-feedback (R2SDF) FFT stage built around a DEPTH-sample delay buffer.
- The delay buffer shifts unconditionally every clock.
- This block counts the input stream, drives the butterfly/bypass select, regenerates output valid aligned to the buffer delay, and supplies twiddle addresses.
- It also flags frame completion and stream protocol errors.

---
 rtl/sdf_stage_ctrl.sv | 62 ++++++
 1 files changed

// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 single-path delay-feedback FFT stage:
// input/output sample counting, butterfly select, output valid and twiddle indexing.
module sdf_stage_ctrl #(
  parameter int DEPTH     = 32,
  parameter int LOG_DEPTH = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 di_en,
  output logic                 bf_sel,
  output logic                 do_en,
  output logic                 do_sel,
  output logic                 tw_en,
  output logic [LOG_DEPTH-1:0] tw_addr,
  output logic                 frame_done,
  output logic                 err,
  output logic                 busy
);

  localparam logic [LOG_DEPTH:0] CNT_ONE  = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH:0] CNT_LAST = '1;

  logic [LOG_DEPTH:0] icnt;
  logic [LOG_DEPTH:0] ocnt;
  logic [DEPTH-1:0]   vld;
  logic               err_cond;

  // A frame that has started may not pause: the delay buffer never stalls.
  assign err_cond = ~di_en & (icnt != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      icnt <= '0;
      ocnt <= '0;
      vld  <= '0;
      err  <= 1'b0;
    end else begin
      err <= err_cond;
      if (err_cond) begin
        icnt <= '0;
        ocnt <= '0;
        vld  <= '0;
      end else begin
        if (di_en)
          icnt <= icnt + CNT_ONE;
        if (do_en)
          ocnt <= ocnt + CNT_ONE;
        vld <= {vld[DEPTH-2:0], di_en};
      end
    end
  end

  // Outputs decode straight from registered state, so they clear with reset.
  assign bf_sel     = icnt[LOG_DEPTH];
  assign do_en      = vld[DEPTH-1];
  assign do_sel     = ocnt[LOG_DEPTH];
  assign tw_en      = do_en & do_sel;
  assign tw_addr    = do_sel ? ocnt[LOG_DEPTH-1:0] : '0;
  assign frame_done = do_en & (ocnt == CNT_LAST);
  assign busy       = (icnt != '0) | (|vld) | (ocnt != '0);

endmodule
